ddr_burst_wr_rd_checker: RTL
============================

Name: ddr_burst_wr_rd_checker

Overview:
- Parametrised AXI4 write/read-back tester for DDR controller bring-up.
- Writes NUM_BURSTS incrementing-address bursts of BURST_LEN beats carrying a deterministic pattern, then reads them back and compares every beat.
- Reports pass/fail, error count and first failing address.
- Sits on the DDR controller's AXI slave port in place of the CPU master during board test.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 128, AXI data width; multiple of 32.
- BASE_ADDR, 32'h8f000000, byte address of the first burst; aligned to DATA_W/8.
- BURST_LEN, 4, beats per burst; 1..256.
- NUM_BURSTS, 2, bursts per write and read phase; 1..65535.
- SEED, 32'h00005678, pattern seed.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; starts a test
- ddr_ready  in  1  controller calibrated/ready
- awaddr  out  ADDR_W  write address
- awlen  out  8  BURST_LEN-1
- awvalid  out  1  AXI AW valid
- awready  in  1  AXI AW ready
- wdata  out  DATA_W  write data
- wstrb  out  DATA_W/8  all ones
- wlast  out  1  last write beat
- wvalid  out  1  AXI W valid
- wready  in  1  AXI W ready
- bresp  in  2  write response
- bvalid  in  1  AXI B valid
- bready  out  1  AXI B ready
- araddr  out  ADDR_W  read address
- arlen  out  8  BURST_LEN-1
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rlast  in  1  last read beat
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- busy  out  1  test in progress
- done  out  1  test finished; sticky until next start or rst
- pass  out  1  valid when done=1
- err_cnt  out  16  mismatch/response-error count, saturating at 16'hFFFF
- first_err_addr  out  ADDR_W  byte address of first failing beat

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. All valids, bready, rready, busy, done, pass = 0. err_cnt = 0. first_err_addr = 0. Beat and burst counters = 0.
- Pattern: global beat index g = burst*BURST_LEN + beat. 32-bit lane k of beat g = SEED + g*(DATA_W/32) + k, mod 2^32.
- Burst address: BASE_ADDR + burst*BURST_LEN*(DATA_W/8), truncated to ADDR_W. No 4KB-boundary check; the integrator keeps bursts within a 4KB page.
- States and transitions:
  - IDLE -> WAIT_RDY on start (start while busy is ignored). Entry clears done, pass, err_cnt and first_err_addr.
  - WAIT_RDY -> AW when ddr_ready=1.
  - AW: awvalid=1 and held stable until awready. Then -> W.
  - W: wvalid=1; a beat advances only on wvalid&wready. wlast=1 on beat BURST_LEN-1. After the last beat -> B.
  - B: bready=1. On bvalid: bresp!=0 adds 1 error and records the burst address as first error if none recorded yet. Next burst -> AW, or after burst NUM_BURSTS-1 -> AR with burst counter = 0.
  - AR: arvalid held until arready. Then -> R.
  - R: rready=1. On each rvalid&rready, compare rdata to the expected pattern. Each beat with mismatch, rresp!=0, or wrong rlast (rlast must be 1 exactly on beat BURST_LEN-1) adds 1 error per beat. First error records its beat address. After the last beat -> AR for the next burst, or -> DONE.
  - DONE: done=1, pass=(err_cnt==0), busy=0 -> IDLE (done/pass held).
- busy=1 in every state except IDLE/DONE.
- Only one AXI transaction outstanding. AW issues before W data; W beats are never sent before the AW handshake completes.
- ddr_ready deasserting in any busy state: abort. Drop all valids/readies the next cycle and go to IDLE with done=0, busy=0. err_cnt is kept.
- start and rst in the same cycle: rst wins.
- err_cnt saturates and does not wrap.

Test Plan:
- Defaults, ideal slave (ready=1, echoing memory):
  - Beat0 wdata = 0x0000567B_0000567A_00005679_00005678; burst1 awaddr = 0x8f000040.
  - done after 8 W beats and 8 R beats; pass=1, err_cnt=0.
- Slave corrupts bit 0 of read beat 5: err_cnt=1, pass=0, first_err_addr=0x8f000050.
- Backpressure: awready/wready/arready random 30% duty. awvalid/wvalid/arvalid and their payloads stay stable until handshake; pass=1.
- bresp=2'b10 on burst 1: err_cnt=1, first_err_addr=0x8f000040; read phase still runs; pass=0.
- Deassert ddr_ready during W beat 2: all valids 0 the next cycle, busy=0, done=0. Re-assert ddr_ready, pulse start: full run passes.
- ddr_ready=0 at start: stays in WAIT_RDY with no AXI activity; proceeds when ddr_ready rises. rst mid-R: all outputs return to reset values.

Source files
------------

// File: rtl/ddr_burst_wr_rd_checker.sv
// AXI4 write/read-back tester for DDR bring-up. It writes NUM_BURSTS INCR bursts of a seeded
// pattern, reads them back, and reports the mismatch count and the first failing byte address.
module ddr_burst_wr_rd_checker #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8f00_0000),
  parameter int              BURST_LEN  = 4,
  parameter int              NUM_BURSTS = 2,
  parameter logic [31:0]     SEED       = 32'h0000_5678
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ddr_ready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_cnt,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int          LANES      = DATA_W / 32;
  localparam int          BYTES      = DATA_W / 8;
  localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  // Expected contents of global beat g: lane k holds SEED + g*LANES + k.
  function automatic logic [DATA_W-1:0] pattern(input logic [31:0] g);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      v[k*32 +: 32] = SEED + g * 32'(LANES) + 32'(k);
    end
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [31:0] g);
    return ADDR_W'(64'(BASE_ADDR) + 64'(g) * 64'(BYTES));
  endfunction

  state_t              r_state;
  logic [7:0]          r_beat;
  logic [15:0]         r_burst;
  logic [31:0]         r_gidx;     // global index of the beat currently on W or expected on R
  logic [ADDR_W-1:0]   r_awaddr, r_araddr, r_first_err_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
  logic                r_busy, r_done, r_pass;
  logic [15:0]         r_err_cnt;

  logic                w_beat_last, w_burst_last, w_abort, w_rd_err, w_err_hit;
  logic [ADDR_W-1:0]   w_err_addr;

  assign w_beat_last  = (r_beat == LAST_BEAT);
  assign w_burst_last = (r_burst == LAST_BURST);
  assign w_abort      = !ddr_ready && (r_state inside {S_AW, S_W, S_B, S_AR, S_R});
  assign w_rd_err     = (rdata != pattern(r_gidx)) || (rresp != 2'b00) || (rlast != w_beat_last);
  assign w_err_hit    = ((r_state == S_B) && bvalid && r_bready && (bresp != 2'b00)) ||
                        ((r_state == S_R) && rvalid && r_rready && w_rd_err);
  assign w_err_addr   = (r_state == S_B) ? r_awaddr : addr_of(r_gidx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_beat           <= '0;
      r_burst          <= '0;
      r_gidx           <= '0;
      r_awaddr         <= '0;
      r_araddr         <= '0;
      r_wdata          <= '0;
      r_awvalid        <= 1'b0;
      r_wvalid         <= 1'b0;
      r_wlast          <= 1'b0;
      r_bready         <= 1'b0;
      r_arvalid        <= 1'b0;
      r_rready         <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state          <= S_WAIT_RDY;
          r_busy           <= 1'b1;
          r_done           <= 1'b0;
          r_pass           <= 1'b0;
          r_err_cnt        <= '0;
          r_first_err_addr <= '0;
          r_burst          <= '0;
          r_beat           <= '0;
          r_gidx           <= '0;
        end
        S_WAIT_RDY: if (ddr_ready) begin
          r_state   <= S_AW;
          r_awvalid <= 1'b1;
          r_awaddr  <= addr_of(r_gidx);
        end
        S_AW: if (awready) begin
          r_state   <= S_W;
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b1;
          r_wdata   <= pattern(r_gidx);
          r_wlast   <= (LAST_BEAT == 8'd0);
          r_beat    <= '0;
        end
        S_W: if (wready) begin
          r_gidx <= r_gidx + 32'd1;
          if (w_beat_last) begin
            r_state  <= S_B;
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_bready <= 1'b1;
          end else begin
            r_beat  <= r_beat + 8'd1;
            r_wdata <= pattern(r_gidx + 32'd1);
            r_wlast <= (r_beat + 8'd1 == LAST_BEAT);
          end
        end
        S_B: if (bvalid) begin
          r_bready <= 1'b0;
          if (w_burst_last) begin
            r_state   <= S_AR;
            r_burst   <= '0;
            r_gidx    <= '0;
            r_arvalid <= 1'b1;
            r_araddr  <= addr_of(32'd0);
          end else begin
            r_state   <= S_AW;
            r_burst   <= r_burst + 16'd1;
            r_awvalid <= 1'b1;
            r_awaddr  <= addr_of(r_gidx);
          end
        end
        S_AR: if (arready) begin
          r_state   <= S_R;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_beat    <= '0;
        end
        S_R: if (rvalid) begin
          r_gidx <= r_gidx + 32'd1;
          if (w_beat_last) begin
            r_rready <= 1'b0;
            r_beat   <= '0;
            if (w_burst_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_AR;
              r_burst   <= r_burst + 16'd1;
              r_arvalid <= 1'b1;
              r_araddr  <= addr_of(r_gidx + 32'd1);
            end
          end else begin
            r_beat <= r_beat + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_pass  <= (r_err_cnt == 16'd0);
        end
        default: r_state <= S_IDLE;
      endcase

      // NOTE: the abort block comes after the case so its non-blocking writes win over
      // anything the case scheduled this cycle; err_cnt is deliberately left untouched.
      if (w_abort) begin
        r_state   <= S_IDLE;
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_wlast   <= 1'b0;
        r_bready  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rready  <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
      end else if (w_err_hit) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0) r_first_err_addr <= w_err_addr;
      end
    end
  end

  assign awaddr         = r_awaddr;
  assign awlen          = LAST_BEAT;
  assign awvalid        = r_awvalid;
  assign wdata          = r_wdata;
  assign wstrb          = '1;
  assign wlast          = r_wlast;
  assign wvalid         = r_wvalid;
  assign bready         = r_bready;
  assign araddr         = r_araddr;
  assign arlen          = LAST_BEAT;
  assign arvalid        = r_arvalid;
  assign rready         = r_rready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;

endmodule
